// File: rtl/sprambe_arb.sv
// Round-robin arbiter sharing one single-port byte-enable RAM among NREQ requesters.
// Define SPRAMBE_ARB_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
module sprambe_arb #(
    parameter int    NREQ    = 4,
    parameter int    DWIDTH  = 128,
    parameter int    AWIDTH  = 4,
    parameter int    BEWIDTH = DWIDTH / 8,
    parameter string REGOUT  = "Y"
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*AWIDTH-1:0]    req_addr,
    input  logic [NREQ*DWIDTH-1:0]    req_data,
    input  logic [NREQ*BEWIDTH-1:0]   req_be,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DWIDTH-1:0]         rsp_data,
    output logic                      mem_we,
    output logic [AWIDTH-1:0]         mem_addr,
    output logic [DWIDTH-1:0]         mem_data,
    output logic [BEWIDTH-1:0]        mem_be,
    input  logic [DWIDTH-1:0]         mem_q
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One stage for the registered command plus one per RAM output edge.
    localparam int LAT = (REGOUT == "Y") ? 3 : 2;

    logic [NREQ-1:0]         grant;
    logic                    found;
    logic [PW-1:0]           g_idx;
    logic [PW-1:0]           c_idx;
    logic [PW-1:0]           base;
    int                      cand;

    logic                    mem_we_q, mem_we_d;
    logic [AWIDTH-1:0]       mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]       mem_data_q, mem_data_d;
    logic [BEWIDTH-1:0]      mem_be_q, mem_be_d;
    logic [LAT-1:0]          pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0][PW-1:0]  pipe_id_q, pipe_id_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]       rsp_data_q, rsp_data_d;

`ifdef SPRAMBE_ARB_RR_EN
    logic [PW-1:0]           ptr_q, ptr_d;
    assign base = ptr_q;
`else
    assign base = '0;
`endif

    // Cyclic search for the first valid requester starting at base.
    always_comb begin
        grant = '0;
        found = 1'b0;
        g_idx = '0;
        c_idx = '0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(base) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            c_idx = PW'(cand);
            if (!found && req_valid[c_idx]) begin
                found = 1'b1;
                g_idx = c_idx;
            end
        end
        if (found) grant[g_idx] = 1'b1;
    end

    assign req_ready = grant & {NREQ{reset_n}};

    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_be_d   = mem_be_q;
`ifdef SPRAMBE_ARB_RR_EN
        ptr_d      = ptr_q;
`endif
        pipe_vld_d    = {pipe_vld_q[LAT-2:0], 1'b0};
        pipe_id_d[0]  = '0;
        for (int k = 1; k < LAT; k++) begin
            pipe_id_d[k] = pipe_id_q[k-1];
        end

        if (found) begin
            mem_we_d      = req_we[g_idx];
            mem_addr_d    = req_addr[int'(g_idx)*AWIDTH +: AWIDTH];
            mem_data_d    = req_data[int'(g_idx)*DWIDTH +: DWIDTH];
            mem_be_d      = req_we[g_idx] ? req_be[int'(g_idx)*BEWIDTH +: BEWIDTH] : '0;
            pipe_vld_d[0] = ~req_we[g_idx];
            pipe_id_d[0]  = g_idx;
`ifdef SPRAMBE_ARB_RR_EN
            ptr_d = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
`endif
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (pipe_vld_q[LAT-1]) begin
            rsp_valid_d[pipe_id_q[LAT-1]] = 1'b1;
            rsp_data_d = mem_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_be_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_id_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef SPRAMBE_ARB_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_be_q    <= mem_be_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SPRAMBE_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_be    = mem_be_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
